// File: rtl/led_mode_sched.sv
// Front-panel controller for the two-key / two-LED board.
// Raw keys are synchronized and debounced. Key 0 steps the display mode
// (OFF -> ON -> BLINK -> ALT) and key 1 steps the blink speed (0 -> 1 -> 2).
// A shared timebase provides the blink phase and a tick pulse at each
// half-period. All outputs are registered.
//
// Handshake note: there is no valid/ready traffic in this block. A press
// event is a single-cycle strobe and is consumed on the clock edge that
// ends the cycle in which it is high; nothing can stall it.
module led_mode_sched #(
   parameter logic [19:0] DEB_MAX  = 20'd1000000,
   parameter logic [24:0] TICK_MAX = 25'd25000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [1:0] key,
   output logic [1:0] led,
   output logic [1:0] mode,
   output logic [1:0] speed,
   output logic       tick
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_ALT   = 2'd3
   } mode_e;

   // Key input conditioning.
   logic [1:0]       key_s1_q;
   logic [1:0]       key_s2_q;
   logic [1:0]       key_stb_q;
   logic [1:0]       key_stb_d;
   logic [1:0]       key_prv_q;
   logic [1:0][19:0] deb_cnt_q;
   logic [1:0][19:0] deb_cnt_d;
   logic [1:0]       press_ev;

   // Mode / speed state.
   mode_e            mode_q;
   logic [1:0]       speed_q;
   logic [1:0]       speed_d;
   logic             restart;

   // Timebase.
   logic [24:0]      period;
   logic [24:0]      tb_cnt_q;
   logic [24:0]      tb_cnt_d;
   logic             phase_q;
   logic             phase_d;
   logic             tick_q;
   logic             tick_d;

   // LED drive.
   logic [1:0]       led_q;
   logic [1:0]       led_d;

   // Two-flop synchronizer per key; reset to the released level.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         key_s1_q <= 2'b11;
         key_s2_q <= 2'b11;
      end else begin
         key_s1_q <= key;
         key_s2_q <= key_s1_q;
      end
   end

   // Debounce next state: count consecutive disagreeing cycles, flip the
   // stable level on the DEB_MAX-th one; any agreeing cycle clears the count.
   always_comb begin
      key_stb_d = key_stb_q;
      deb_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (key_s2_q[i] != key_stb_q[i]) begin
            if (deb_cnt_q[i] == DEB_MAX - 20'd1) begin
               key_stb_d[i] = key_s2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
            end
         end
      end
   end

   // Debounce registers plus a one-cycle-delayed copy of the stable level.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         key_stb_q <= 2'b11;
         key_prv_q <= 2'b11;
         deb_cnt_q <= '0;
      end else begin
         key_stb_q <= key_stb_d;
         key_prv_q <= key_stb_q;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   // A press is high for the single cycle after the stable level falls;
   // releases and long holds generate nothing further.
   assign press_ev = key_prv_q & ~key_stb_q;

   // Any press changes mode or speed, so it also restarts the timebase.
   assign restart = press_ev[0] | press_ev[1];

   // Mode FSM: each key 0 press advances one state, ALT wraps to OFF.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         mode_q <= MODE_OFF;
      end else if (press_ev[0]) begin
         case (mode_q)
            MODE_OFF:   mode_q <= MODE_ON;
            MODE_ON:    mode_q <= MODE_BLINK;
            MODE_BLINK: mode_q <= MODE_ALT;
            MODE_ALT:   mode_q <= MODE_OFF;
            default:    mode_q <= MODE_OFF;
         endcase
      end
   end

   // Speed next state: 0 -> 1 -> 2 -> 0; level 3 is never produced.
   always_comb begin
      speed_d = speed_q;
      if (press_ev[1]) begin
         speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
      end
   end

   // Speed register.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         speed_q <= 2'd0;
      end else begin
         speed_q <= speed_d;
      end
   end

   // Half-period length for the current speed level.
   always_comb begin
      case (speed_q)
         2'd0:    period = TICK_MAX;
         2'd1:    period = TICK_MAX >> 1;
         default: period = TICK_MAX >> 2;
      endcase
   end

   // Timebase next state: free-running 0..period-1, toggling phase and
   // pulsing tick on wrap; a restart clears it and swallows the tick.
   always_comb begin
      tb_cnt_d = tb_cnt_q + 25'd1;
      phase_d  = phase_q;
      tick_d   = 1'b0;
      if (restart) begin
         tb_cnt_d = '0;
         phase_d  = 1'b0;
      end else if (tb_cnt_q >= period - 25'd1) begin
         tb_cnt_d = '0;
         phase_d  = ~phase_q;
         tick_d   = 1'b1;
      end
   end

   // Timebase registers.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         tb_cnt_q <= '0;
         phase_q  <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         tb_cnt_q <= tb_cnt_d;
         phase_q  <= phase_d;
         tick_q   <= tick_d;
      end
   end

   // LED pattern from the current mode and blink phase.
   always_comb begin
      led_d = 2'b00;
      case (mode_q)
         MODE_OFF:   led_d = 2'b00;
         MODE_ON:    led_d = 2'b11;
         MODE_BLINK: led_d = {2{phase_q}};
         MODE_ALT:   led_d = phase_q ? 2'b10 : 2'b01;
         default:    led_d = 2'b00;
      endcase
   end

   // LED output register, one cycle behind mode/phase.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         led_q <= 2'b00;
      end else begin
         led_q <= led_d;
      end
   end

   assign led   = led_q;
   assign mode  = mode_q;
   assign speed = speed_q;
   assign tick  = tick_q;

endmodule

// File: tb/tb_led_mode_sched.sv
// Bench for led_mode_sched with DEB_MAX=4 and TICK_MAX=16.
// Expected {mode,speed} pairs are queued when a press is driven and are
// popped whenever the DUT's mode or speed moves.
module tb_led_mode_sched;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [1:0] key;
   logic [1:0] led;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       tick;

   int checks = 0;
   int passes = 0;

   logic [3:0] exp_q[$];
   logic [1:0] m_mode  = 2'd0;
   logic [1:0] m_speed = 2'd0;
   logic [3:0] mon_prev = 4'h0;
   logic [3:0] mon_got;
   logic [3:0] mon_exp;

   led_mode_sched #(
      .DEB_MAX  (20'd4),
      .TICK_MAX (25'd16)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key     (key),
      .led     (led),
      .mode    (mode),
      .speed   (speed),
      .tick    (tick)
   );

   // Clock: 10 time-unit period.
   always #5 sys_clk = ~sys_clk;

   // Scoreboard: every change of {mode,speed} outside reset pops one entry.
   always @(negedge sys_clk) begin
      mon_got = {mode, speed};
      if (sys_rst === 1'b1 && mon_got !== mon_prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_unexpected: got mode/speed %b, no change expected", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp)
               $display("FAIL scoreboard_value: got mode/speed %b expected %b", mon_got, mon_exp);
            else
               passes++;
         end
      end
      mon_prev = mon_got;
   end

   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Update the model, queue the expected result and press the key(s).
   task automatic drive_press(input logic [1:0] k);
      if (k[0]) m_mode = m_mode + 2'd1;
      if (k[1]) m_speed = (m_speed == 2'd2) ? 2'd0 : m_speed + 2'd1;
      exp_q.push_back({m_mode, m_speed});
      key = ~k;
   endtask

   task automatic press(input logic [1:0] k);
      drive_press(k);
      step(20);
      key = 2'b11;
      step(12);
   endtask

   // Cycles until the first LED change and between the first two changes.
   task automatic measure_led(output int first, output int interval);
      logic [1:0] prev;
      int t1;
      int t2;
      t1 = -1;
      t2 = -1;
      prev = led;
      for (int i = 1; i <= 60 && t2 < 0; i++) begin
         step(1);
         if (led !== prev) begin
            if (t1 < 0) t1 = i;
            else t2 = i;
            prev = led;
         end
      end
      first = t1;
      interval = (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1;
   endtask

   task automatic test_reset();
      int nt;
      int bad;
      int last;
      int chg;
      logic [3:0] prev;
      key = 2'b11;
      sys_rst = 1'b1;
      #3 sys_rst = 1'b0;
      step(3);
      checks++; if (led !== 2'b00) $display("FAIL reset_led: got %b expected 00", led); else passes++;
      checks++; if (mode !== 2'd0) $display("FAIL reset_mode: got %0d expected 0", mode); else passes++;
      checks++; if (speed !== 2'd0) $display("FAIL reset_speed: got %0d expected 0", speed); else passes++;
      checks++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", tick); else passes++;
      sys_rst = 1'b1;
      nt = 0; bad = 0; last = -1; chg = 0;
      prev = {mode, speed};
      for (int i = 1; i <= 200; i++) begin
         step(1);
         if ({mode, speed} !== prev) chg++;
         if (tick === 1'b1) begin
            if (last >= 0 && (i - last) != 16) bad++;
            if (last < 0 && i != 16) bad++;
            last = i;
            nt++;
         end
      end
      checks++; if (nt != 12) $display("FAIL idle_tick_count: got %0d expected 12", nt); else passes++;
      checks++; if (bad != 0) $display("FAIL idle_tick_spacing: got %0d bad intervals expected 0", bad); else passes++;
      checks++; if (chg != 0) $display("FAIL idle_no_change: got %0d changes expected 0", chg); else passes++;
   endtask

   task automatic test_mode_cycle();
      logic [1:0] prev;
      logic [1:0] led_at;
      logic [1:0] led_nx;
      int chg;
      for (int p = 0; p < 4; p++) begin
         prev = mode;
         chg = -1;
         led_at = 2'bxx;
         led_nx = 2'bxx;
         drive_press(2'b01);
         for (int i = 1; i <= 20; i++) begin
            step(1);
            if (chg < 0 && mode !== prev) chg = i;
            if (i == chg) led_at = led;
            if (chg > 0 && i == chg + 1) led_nx = led;
         end
         checks++; if (chg != 7) $display("FAIL mode_latency: got %0d cycles expected 7", chg); else passes++;
         checks++; if (mode !== m_mode) $display("FAIL mode_value: got %0d expected %0d", mode, m_mode); else passes++;
         if (p == 0) begin
            checks++; if (led_at !== 2'b00) $display("FAIL on_led_lag: got %b expected 00", led_at); else passes++;
            checks++; if (led_nx !== 2'b11) $display("FAIL on_led: got %b expected 11", led_nx); else passes++;
         end
         key = 2'b11;
         step(12);
      end
   endtask

   task automatic test_bounce();
      logic [1:0] prev;
      int chg_toggle;
      int chg_total;
      prev = mode;
      chg_toggle = 0;
      chg_total = 0;
      drive_press(2'b01);
      for (int i = 0; i < 30; i++) begin
         key = {1'b1, ((i / 2) % 2) != 0};
         step(1);
         if (mode !== prev) begin chg_toggle++; prev = mode; end
      end
      chg_total = chg_toggle;
      key = 2'b10;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (mode !== prev) begin chg_total++; prev = mode; end
      end
      checks++; if (chg_toggle != 0) $display("FAIL bounce_quiet: got %0d changes expected 0", chg_toggle); else passes++;
      checks++; if (chg_total != 1) $display("FAIL bounce_single: got %0d changes expected 1", chg_total); else passes++;
      checks++; if (mode !== m_mode) $display("FAIL bounce_mode: got %0d expected %0d", mode, m_mode); else passes++;
      key = 2'b11;
      step(12);
   endtask

   task automatic test_speed();
      int first;
      int ivl;
      int chg;
      int ftick;
      logic tick_at;
      logic [1:0] prev_s;
      press(2'b01);
      checks++; if (mode !== 2'd2) $display("FAIL blink_mode: got %0d expected 2", mode); else passes++;
      measure_led(first, ivl);
      checks++; if (ivl != 16) $display("FAIL blink_ivl_s0: got %0d expected 16", ivl); else passes++;
      checks++; if (led !== 2'b00 && led !== 2'b11) $display("FAIL blink_pattern: got %b expected 00 or 11", led); else passes++;
      prev_s = speed;
      chg = -1; ftick = -1; tick_at = 1'bx;
      drive_press(2'b10);
      for (int i = 1; i <= 30; i++) begin
         if (i == 21) key = 2'b11;
         step(1);
         if (chg < 0 && speed !== prev_s) begin chg = i; tick_at = tick; end
         else if (chg > 0 && ftick < 0 && tick === 1'b1) ftick = i;
      end
      checks++; if (chg != 7) $display("FAIL speed_latency: got %0d expected 7", chg); else passes++;
      checks++; if (tick_at !== 1'b0) $display("FAIL speed_tick_suppress: got %b expected 0", tick_at); else passes++;
      checks++; if (ftick - chg != 8) $display("FAIL speed_first_tick: got %0d expected 8", ftick - chg); else passes++;
      step(12);
      measure_led(first, ivl);
      checks++; if (ivl != 8) $display("FAIL blink_ivl_s1: got %0d expected 8", ivl); else passes++;
      press(2'b10);
      checks++; if (speed !== 2'd2) $display("FAIL speed_two: got %0d expected 2", speed); else passes++;
      measure_led(first, ivl);
      checks++; if (ivl != 4) $display("FAIL blink_ivl_s2: got %0d expected 4", ivl); else passes++;
      press(2'b10);
      checks++; if (speed !== 2'd0) $display("FAIL speed_wrap: got %0d expected 0", speed); else passes++;
      measure_led(first, ivl);
      checks++; if (ivl != 16) $display("FAIL blink_ivl_s0b: got %0d expected 16", ivl); else passes++;
   endtask

   task automatic test_both_keys();
      int first;
      int ivl;
      int mchg;
      int schg;
      int ftick;
      logic tick_at;
      logic [1:0] led_nx;
      logic [1:0] prev_m;
      logic [1:0] prev_s;
      press(2'b01);
      checks++; if (mode !== 2'd3) $display("FAIL alt_mode: got %0d expected 3", mode); else passes++;
      measure_led(first, ivl);
      checks++; if (ivl != 16) $display("FAIL alt_ivl: got %0d expected 16", ivl); else passes++;
      checks++; if (led !== 2'b01 && led !== 2'b10) $display("FAIL alt_pattern: got %b expected 01 or 10", led); else passes++;
      prev_m = mode; prev_s = speed;
      mchg = -1; schg = -1; ftick = -1; tick_at = 1'bx; led_nx = 2'bxx;
      drive_press(2'b11);
      for (int i = 1; i <= 30; i++) begin
         if (i == 21) key = 2'b11;
         step(1);
         if (schg < 0 && speed !== prev_s) schg = i;
         if (mchg < 0 && mode !== prev_m) begin mchg = i; tick_at = tick; end
         else if (mchg > 0) begin
            if (i == mchg + 1) led_nx = led;
            if (ftick < 0 && tick === 1'b1) ftick = i;
         end
      end
      checks++; if (mchg != 7) $display("FAIL both_mode_latency: got %0d expected 7", mchg); else passes++;
      checks++; if (schg != 7) $display("FAIL both_speed_latency: got %0d expected 7", schg); else passes++;
      checks++; if (tick_at !== 1'b0) $display("FAIL both_tick_suppress: got %b expected 0", tick_at); else passes++;
      checks++; if (led_nx !== 2'b00) $display("FAIL both_led_off: got %b expected 00", led_nx); else passes++;
      checks++; if (ftick - mchg != 8) $display("FAIL both_restart: got %0d expected 8", ftick - mchg); else passes++;
      step(12);
   endtask

   task automatic test_reset_mid();
      int chg;
      int nchg;
      logic [1:0] prev;
      key = 2'b10;
      step(3);
      sys_rst = 1'b0;
      #1;
      checks++; if (led !== 2'b00) $display("FAIL midrst_led: got %b expected 00", led); else passes++;
      checks++; if (mode !== 2'd0) $display("FAIL midrst_mode: got %0d expected 0", mode); else passes++;
      checks++; if (speed !== 2'd0) $display("FAIL midrst_speed: got %0d expected 0", speed); else passes++;
      checks++; if (tick !== 1'b0) $display("FAIL midrst_tick: got %b expected 0", tick); else passes++;
      checks++; if (exp_q.size() != 0) $display("FAIL midrst_pending: got %0d queued expected 0", exp_q.size()); else passes++;
      exp_q.delete();
      m_mode = 2'd0;
      m_speed = 2'd0;
      step(3);
      sys_rst = 1'b1;
      m_mode = 2'd1;
      exp_q.push_back({m_mode, m_speed});
      prev = mode;
      chg = -1; nchg = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (mode !== prev) begin
            nchg++;
            if (chg < 0) chg = i;
            prev = mode;
         end
      end
      checks++; if (chg != 7) $display("FAIL midrst_latency: got %0d expected 7", chg); else passes++;
      checks++; if (nchg != 1) $display("FAIL midrst_single: got %0d changes expected 1", nchg); else passes++;
      key = 2'b11;
      step(20);
      checks++; if (mode !== 2'd1) $display("FAIL midrst_release: got %0d expected 1", mode); else passes++;
   endtask

   initial begin
      test_reset();
      test_mode_cycle();
      test_bounce();
      test_speed();
      test_both_keys();
      test_reset_mid();
      step(2);
      checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
